// File: rtl/point_sum_accumulator_if.sv
// Point type for the MSM datapath and the stream interface of point_sum_accumulator.
// The point is a stand-in group element: componentwise 16-bit sum, identity = inf_point.
package elliptic_curve_structs;
  typedef struct packed {
    logic        inf;
    logic [15:0] x;
    logic [15:0] y;
  } curve_point_t;

  localparam curve_point_t inf_point = '{inf: 1'b1, x: 16'h0000, y: 16'h0000};
endpackage

interface point_sum_accumulator_if #(
  parameter int CNT_W = 16
);
  import elliptic_curve_structs::*;

  logic             in_valid;
  logic             in_ready;
  curve_point_t     in_point;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  curve_point_t     out_sum;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  modport master (
    output in_valid, in_point, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, busy
  );

  modport slave (
    input  in_valid, in_point, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, busy
  );
endinterface

// File: rtl/point_sum_accumulator.sv
// Batch accumulator for k_i*P_i products: input FIFO, one multi-cycle point_add, sum output.
// Optional build macro ACC_SKIP_INF_EN: bypass the adder when either operand is inf_point.

module point_add
  import elliptic_curve_structs::*;
#(
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         add_rst_i,
  input  curve_point_t p_i,
  input  curve_point_t q_i,
  output curve_point_t r_o,
  output logic         done_o
);
  localparam int LW = $clog2(LAT + 1);

  logic [LW-1:0] tmr_q;
  logic          done_q;
  curve_point_t  r_q;
  curve_point_t  sum_d;

  always_comb begin
    sum_d = inf_point;
    if (p_i.inf) begin
      sum_d = q_i;
    end else if (q_i.inf) begin
      sum_d = p_i;
    end else begin
      sum_d.inf = 1'b0;
      sum_d.x   = p_i.x + q_i.x;
      sum_d.y   = p_i.y + q_i.y;
    end
  end

  // Down-counter models the fixed pipeline latency of the real curve adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q  <= LW'(LAT - 1);
      done_q <= 1'b0;
      r_q    <= inf_point;
    end else if (add_rst_i) begin
      tmr_q  <= LW'(LAT - 1);
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (tmr_q == '0) begin
        done_q <= 1'b1;
        r_q    <= sum_d;
      end else begin
        tmr_q <= tmr_q - 1'b1;
      end
    end
  end

  assign r_o    = r_q;
  assign done_o = done_q;
endmodule

// state      | meaning
// S_WAIT     | adder held in reset; pop next product when FIFO non-empty
// S_ADD_RST  | one-cycle adder reset with operands acc / q_reg
// S_ADD_WAIT | adder running; take R into acc on done
// S_EMIT     | batch sum presented until out_ready
module point_sum_accumulator
  import elliptic_curve_structs::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int ADD_LAT    = 3
) (
  input logic                    clk,
  input logic                    rst,
  point_sum_accumulator_if.slave acc_if
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_WAIT, S_ADD_RST, S_ADD_WAIT, S_EMIT} state_t;

  typedef struct packed {
    curve_point_t pt;
    logic         last;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, push, pop;
  entry_t           head;

  state_t           state_q;
  curve_point_t     acc_q, q_reg_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             out_valid_q, add_rst_q;
  curve_point_t     add_r;
  logic             add_done;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = acc_if.in_valid && !fifo_full;
  assign pop        = (state_q == S_WAIT) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{pt: acc_if.in_point, last: acc_if.in_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      acc_q       <= inf_point;
      q_reg_q     <= inf_point;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      add_rst_q   <= 1'b1;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (pop) begin
            cnt_q <= cnt_inc;
`ifdef ACC_SKIP_INF_EN
            if (head.pt == inf_point || acc_q == inf_point) begin
              if (acc_q == inf_point) acc_q <= head.pt;
              if (head.last) begin
                state_q     <= S_EMIT;
                out_valid_q <= 1'b1;
              end
            end else begin
              q_reg_q <= head.pt;
              last_q  <= head.last;
              state_q <= S_ADD_RST;
            end
`else
            q_reg_q <= head.pt;
            last_q  <= head.last;
            state_q <= S_ADD_RST;
`endif
          end
        end
        S_ADD_RST: begin
          add_rst_q <= 1'b0;
          state_q   <= S_ADD_WAIT;
        end
        S_ADD_WAIT: begin
          if (add_done) begin
            acc_q     <= add_r;
            add_rst_q <= 1'b1;
            if (last_q) begin
              state_q     <= S_EMIT;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_EMIT: begin
          if (acc_if.out_ready) begin
            acc_q       <= inf_point;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  point_add #(.LAT(ADD_LAT)) u_add (
    .clk      (clk),
    .rst      (rst),
    .add_rst_i(add_rst_q),
    .p_i      (acc_q),
    .q_i      (q_reg_q),
    .r_o      (add_r),
    .done_o   (add_done)
  );

  assign acc_if.in_ready  = !fifo_full;
  assign acc_if.out_valid = out_valid_q;
  assign acc_if.out_sum   = acc_q;
  assign acc_if.out_count = cnt_q;
  assign acc_if.busy      = (state_q != S_WAIT) || !fifo_empty;
endmodule

// File: tb/tb_point_sum_accumulator.sv
// Randomized bench for point_sum_accumulator with a batch-sum reference model and literal anchors.
module tb_point_sum_accumulator;
  import elliptic_curve_structs::*;

  localparam int CNT_W = 16;

  typedef struct {
    curve_point_t sum;
    int           cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  point_sum_accumulator_if #(.CNT_W(CNT_W)) acc_if ();

  point_sum_accumulator #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .acc_if(acc_if)
  );

  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  logic [15:0]  bx, by;
  bit           bany;
  int           bn;
  int           n_out = 0;
  int           n_push = 0;
  curve_point_t last_sum;
  int           last_cnt;
  bit           saw_stall;
  bit           rand_phase;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic curve_point_t mk(input int n);
    curve_point_t p;
    p.inf = (n == 0);
    p.x   = (n == 0) ? 16'h0 : 16'(n * 32'h1234);
    p.y   = (n == 0) ? 16'h0 : 16'(n * 32'h0ABC);
    return p;
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    bx = '0; by = '0; bany = 1'b0; bn = 0;
  endfunction

  // Reference: each batch sum is the wrapped componentwise sum of its non-identity points.
  initial begin
    clear_model();
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (acc_if.in_valid && acc_if.in_ready) begin
          n_push++;
          bn++;
          if (!acc_if.in_point.inf) begin
            bx   = bx + acc_if.in_point.x;
            by   = by + acc_if.in_point.y;
            bany = 1'b1;
          end
          if (acc_if.in_last) begin
            exp_q.push_back('{sum: bany ? curve_point_t'({1'b0, bx, by}) : inf_point,
                              cnt: (bn > 65535) ? 65535 : bn});
            bx = '0; by = '0; bany = 1'b0; bn = 0;
          end
        end
        if (acc_if.out_valid && acc_if.out_ready) begin
          last_sum = acc_if.out_sum;
          last_cnt = int'(acc_if.out_count);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && acc_if.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(acc_if.out_valid), 64'd0);
        end else begin
          check("out_sum", 64'(acc_if.out_sum), 64'(exp_q[0].sum));
          check("out_count", 64'(acc_if.out_count), 64'(exp_q[0].cnt));
        end
      end
    end
  end

  task automatic push(input curve_point_t p, input bit last);
    bit ok;
    int guard;
    acc_if.in_valid = 1'b1;
    acc_if.in_point = p;
    acc_if.in_last  = last;
    ok = 1'b0;
    guard = 0;
    while (!ok && guard < 300) begin
      @(negedge clk);
      ok = acc_if.in_ready;
      if (!ok) saw_stall = 1'b1;
      @(posedge clk);
      guard++;
    end
    #1;
    acc_if.in_valid = 1'b0;
    if (!ok) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (n_out < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(name, 64'(n_out >= target), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int c;
    c = 0;
    while (c < budget) begin
      @(negedge clk);
      if (acc_if.out_valid) break;
      c++;
    end
    check(name, 64'(acc_if.out_valid), 64'd1);
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    clear_model();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p0, lat;
    curve_point_t hold_sum;
    logic [CNT_W-1:0] hold_cnt;
    curve_point_t rp;
    bit rl;

    acc_if.in_valid  = 1'b0;
    acc_if.in_point  = inf_point;
    acc_if.in_last   = 1'b0;
    acc_if.out_ready = 1'b0;

    // Reset state and idle behaviour
    assert_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(acc_if.out_valid), 64'd0);
    check("rst_in_ready", 64'(acc_if.in_ready), 64'd1);
    check("rst_busy", 64'(acc_if.busy), 64'd0);
    check("rst_out_count", 64'(acc_if.out_count), 64'd0);
    check("rst_out_sum", 64'(acc_if.out_sum), 64'(inf_point));
    release_reset();
    repeat (5) @(posedge clk);
    #1;
    check("idle_out_valid", 64'(acc_if.out_valid), 64'd0);
    check("idle_busy", 64'(acc_if.busy), 64'd0);
    check("idle_in_ready", 64'(acc_if.in_ready), 64'd1);

    // Single-item batch
    acc_if.out_ready = 1'b1;
    base = n_out;
    push(mk(1), 1'b1);
    wait_out(base + 1, 200, "single_done");
    repeat (10) @(posedge clk);
    #1;
    check("single_once", 64'(n_out), 64'(base + 1));
    check("single_sum_lit", 64'(last_sum), 64'({1'b0, 16'h1234, 16'h0ABC}));
    check("single_cnt", 64'(last_cnt), 64'd1);

    // G + 2G + 3G
    base = n_out;
    push(mk(1), 1'b0);
    push(mk(2), 1'b0);
    push(mk(3), 1'b1);
    wait_out(base + 1, 300, "six_done");
    check("six_sum_lit", 64'(last_sum), 64'({1'b0, 16'h6D38, 16'h4068}));
    check("six_cnt", 64'(last_cnt), 64'd3);

    // Back-pressure: in_valid held, two 4-item batches, sink stalled
    acc_if.out_ready = 1'b0;
    saw_stall = 1'b0;
    base = n_out;
    p0 = n_push;
    for (int i = 0; i < 8; i++) push(mk(i + 5), (i == 3) || (i == 7));
    check("bp_stall_seen", 64'(saw_stall), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check("bp_full_in_ready", 64'(acc_if.in_ready), 64'd0);
    check("bp_busy", 64'(acc_if.busy), 64'd1);
    acc_if.out_ready = 1'b1;
    wait_out(base + 2, 600, "bp_done");
    check("bp_pushes", 64'(n_push - p0), 64'd8);
    drain("bp_drain");

    // Hold in EMIT, then restart from identity
    acc_if.out_ready = 1'b0;
    push(mk(1), 1'b0);
    push(mk(2), 1'b1);
    wait_valid(200, "hold_valid");
    hold_sum = acc_if.out_sum;
    hold_cnt = acc_if.out_count;
    check("hold_sum_lit", 64'(hold_sum), 64'({1'b0, 16'h369C, 16'h2034}));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_sum_stable", 64'(acc_if.out_sum), 64'(hold_sum));
      check("hold_cnt_stable", 64'(acc_if.out_count), 64'(hold_cnt));
    end
    base = n_out;
    @(posedge clk);
    #1;
    acc_if.out_ready = 1'b1;
    wait_out(base + 1, 50, "hold_release");
    push(mk(1), 1'b1);
    wait_out(base + 2, 200, "restart_done");
    check("restart_sum", 64'(last_sum), 64'(mk(1)));
    check("restart_cnt", 64'(last_cnt), 64'd1);

    // Reset while the adder is running
    push(mk(1), 1'b0);
    push(mk(2), 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(acc_if.busy), 64'd1);
    assert_reset();
    check("mid_rst_busy", 64'(acc_if.busy), 64'd0);
    check("mid_rst_out_valid", 64'(acc_if.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(acc_if.in_ready), 64'd1);
    release_reset();
    base = n_out;
    push(mk(1), 1'b1);
    wait_out(base + 1, 200, "post_rst_done");
    check("post_rst_sum", 64'(last_sum), 64'(mk(1)));
    check("post_rst_cnt", 64'(last_cnt), 64'd1);

    // Reset while presenting a sum: out_valid falls immediately
    acc_if.out_ready = 1'b0;
    push(mk(4), 1'b1);
    wait_valid(200, "emit_valid");
    #2;
    assert_reset();
    check("emit_rst_out_valid", 64'(acc_if.out_valid), 64'd0);
    release_reset();
    acc_if.out_ready = 1'b1;

    // Identity handling (and bypass latency when enabled)
    base = n_out;
    push(mk(1), 1'b1);
`ifdef ACC_SKIP_INF_EN
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_if.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("skip_latency", 64'(lat), 64'd2);
`else
    lat = 0;
`endif
    wait_out(base + 1, 200, "lat_done");
    push(inf_point, 1'b0);
    push(mk(1), 1'b1);
    wait_out(base + 2, 200, "inf_first_done");
    check("inf_first_sum", 64'(last_sum), 64'(mk(1)));
    check("inf_first_cnt", 64'(last_cnt), 64'd2);
    push(mk(1), 1'b0);
    push(inf_point, 1'b1);
    wait_out(base + 3, 200, "inf_last_done");
    check("inf_last_sum", 64'(last_sum), 64'(mk(1)));
    check("inf_last_cnt", 64'(last_cnt), 64'd2);
    push(inf_point, 1'b1);
    wait_out(base + 4, 200, "inf_only_done");
    check("inf_only_sum", 64'(last_sum), 64'(inf_point));

    // Randomized batches with a randomly stalling sink
    rand_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rp = ($urandom_range(4) == 0) ? inf_point
               : curve_point_t'({1'b0, 16'($urandom), 16'($urandom)});
          rl = ($urandom_range(3) == 0) || (i == 39);
          if ($urandom_range(2) != 0) begin
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
          end
          push(rp, rl);
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          acc_if.out_ready = 1'($urandom_range(1));
        end
      end
    join
    acc_if.out_ready = 1'b1;
    drain("rand_drain");
    repeat (5) @(posedge clk);
    #1;
    check("final_idle_busy", 64'(acc_if.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
